if_id_skid_stage: RTL and testbench
===================================

Name: if_id_skid_stage

Overview:
- Parametrised next-generation IF/ID pipeline register for the MIPS pipeline: sits between fetch and decode.
- Adds a valid/ready handshake on both sides, a 2-entry skid buffer so fetch may run one word ahead of a stalled decode, and a synchronous flush that squashes stored words to NOPs on branch/jump redirect.
- All outputs are registered; in_ready comes from state only, with no combinational path from out_ready.
- Includes a saturating stall counter for performance debug.

Parameters:
- INSTR_W, 32, instruction width in bits.
- PC_W, 32, program-counter width in bits.
- NOP_INSTR, 32'h0000_0000, value driven on instr_out when the stage holds no valid word (INSTR_W bits).
- RESET_PC, 0, value of pc_out after reset (PC_W bits).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash of all stored words.
- in_valid  input  1  fetch presents a word.
- in_ready  output  1  stage can accept a word this cycle.
- instr_in  input  INSTR_W  fetched instruction.
- pc_in  input  PC_W  PC of the fetched instruction.
- out_valid  output  1  decode-side word valid.
- out_ready  input  1  decode accepts the word this cycle.
- instr_out  output  INSTR_W  instruction to decode.
- pc_out  output  PC_W  PC to decode.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (asynchronous, active-high):
  - state=EMPTY, out_valid=0, instr_out=NOP_INSTR, pc_out=RESET_PC.
  - Skid registers are cleared to NOP_INSTR/RESET_PC; stall_cnt=0.
  - in_ready is forced to 0 while reset is high.
  - Reset mid-transfer discards all stored words.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Deliver = out_valid & out_ready.
  - Both are sampled on the rising clock edge.
- State and derived outputs:
  - States: EMPTY (0 words), ONE (main register valid), TWO (main + skid valid).
  - in_ready = (state != TWO) & !reset.
  - out_valid = (state != EMPTY).
- EMPTY:
  - Accept: main<=input, go to ONE (latency 1 cycle, input to out_valid).
  - Otherwise stay.
- ONE:
  - Accept & deliver: main<=input, stay in ONE (full throughput, 1 word/cycle).
  - Accept only: skid<=input, go to TWO.
  - Deliver only: go to EMPTY; instr_out<=NOP_INSTR, pc_out holds its last value.
  - Neither: hold.
- TWO:
  - in_ready=0, so no accept is possible.
  - Deliver: main<=skid, go to ONE; skid cleared to NOP_INSTR.
  - No deliver: hold.
- Ordering: strict FIFO; words are never dropped or duplicated except by flush or reset.
- Flush:
  - Takes priority over accept in the same cycle: the incoming word is dropped and in_valid is ignored.
  - The word on the outputs in the flush cycle counts as delivered if out_ready=1.
  - Next state is EMPTY, out_valid=0, instr_out=NOP_INSTR, and the skid is cleared.
  - pc_out holds.
  - Flush while EMPTY is a no-op.
- stall_cnt:
  - Increments each cycle out_valid=1 & out_ready=0 & !flush.
  - Saturates at 2^CNT_W-1; does not wrap.
  - Cleared only by reset.
- Width rules:
  - Data is passed through unmodified at INSTR_W/PC_W.
  - NOP_INSTR and RESET_PC are truncated or zero-extended to the port width.

Test Plan:
- Streaming: in_valid=1, out_ready=1, PCs 0x0,0x4,0x8,… with instr 0x2001000N → out_valid rises 1 cycle later; one word per cycle in order; stall_cnt stays 0.
- Back-pressure:
  - Drive out_ready=0 while offering A(pc 0x10) then B(pc 0x14) → in_ready drops after B; state=TWO; outputs hold A; stall_cnt increments each cycle.
  - Raise out_ready → A, then B, delivered on consecutive cycles; in_ready returns to 1 one cycle after the first delivery.
- Flush while TWO with in_valid=1 offering C, out_ready=0 → next cycle out_valid=0, instr_out=0x00000000, in_ready=1; C, A and B are never seen downstream.
- Asynchronous reset asserted mid-cycle with the stage in ONE → out_valid=0, instr_out=NOP_INSTR, pc_out=RESET_PC immediately, without waiting for a clock edge; in_ready=0 until reset is released.
- Saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt reads 15 and stays 15.
- Drain-to-empty: single word with out_ready=1 → after delivery out_valid=0, instr_out=NOP_INSTR, pc_out retains the delivered PC.

Source files
------------

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with valid/ready handshakes, a 2-entry skid buffer,
// synchronous flush to NOP and a saturating stall counter for perf debug.
module if_id_skid_stage #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]         state, state_nxt;
  logic [INSTR_W-1:0] main_instr_nxt;
  logic [PC_W-1:0]    main_pc_nxt;
  logic [INSTR_W-1:0] skid_instr, skid_instr_nxt;
  logic [PC_W-1:0]    skid_pc, skid_pc_nxt;
  logic               accept, deliver;

  // in_ready depends only on state and reset, never on out_ready.
  assign in_ready = (state != TWO) & ~reset;
  assign accept   = in_valid & in_ready;
  assign deliver  = out_valid & out_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt      = state;
    main_instr_nxt = instr_out;
    main_pc_nxt    = pc_out;
    skid_instr_nxt = skid_instr;
    skid_pc_nxt    = skid_pc;

    if (flush) begin
      // Flush wins over accept; pc_out deliberately holds for debug visibility.
      state_nxt      = EMPTY;
      main_instr_nxt = NOP_INSTR;
      skid_instr_nxt = NOP_INSTR;
      skid_pc_nxt    = RESET_PC;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt      = ONE;
            main_instr_nxt = instr_in;
            main_pc_nxt    = pc_in;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            main_instr_nxt = instr_in;
            main_pc_nxt    = pc_in;
          end else if (accept) begin
            state_nxt      = TWO;
            skid_instr_nxt = instr_in;
            skid_pc_nxt    = pc_in;
          end else if (deliver) begin
            state_nxt      = EMPTY;
            main_instr_nxt = NOP_INSTR;
          end
        end
        TWO: begin
          if (deliver) begin
            state_nxt      = ONE;
            main_instr_nxt = skid_instr;
            main_pc_nxt    = skid_pc;
            skid_instr_nxt = NOP_INSTR;
            skid_pc_nxt    = RESET_PC;
          end
        end
        default: begin
          state_nxt      = EMPTY;
          main_instr_nxt = NOP_INSTR;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      instr_out  <= NOP_INSTR;
      pc_out     <= RESET_PC;
      skid_instr <= NOP_INSTR;
      skid_pc    <= RESET_PC;
      stall_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      out_valid  <= (state_nxt != EMPTY);
      instr_out  <= main_instr_nxt;
      pc_out     <= main_pc_nxt;
      skid_instr <= skid_instr_nxt;
      skid_pc    <= skid_pc_nxt;
      if (out_valid && !out_ready && !flush && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed, table-driven bench for if_id_skid_stage: streaming, back-pressure,
// flush, async reset and stall counter saturation (CNT_W=4).
module tb_if_id_skid_stage;

  localparam int          INSTR_W  = 32;
  localparam int          PC_W     = 32;
  localparam int          CNT_W    = 4;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] RST_PC   = 32'hBFC0_0000;

  logic               clk = 1'b0;
  logic               reset;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr_in;
  logic [PC_W-1:0]    pc_in;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    pc_out;
  logic [CNT_W-1:0]   stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  if_id_skid_stage #(
    .INSTR_W  (INSTR_W),
    .PC_W     (PC_W),
    .NOP_INSTR(NOP),
    .RESET_PC (RST_PC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr_in (instr_in),
    .pc_in    (pc_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .instr_out(instr_out),
    .pc_out   (pc_out),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] ii;
    logic [31:0] pi;
    logic        ordy;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    logic        eir;
    logic [3:0]  es;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [31:0] ei,
                           input logic [31:0] ep, input logic eir, input logic [3:0] es);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    check({tag, ".instr_out"}, 64'(instr_out), 64'(ei));
    check({tag, ".pc_out"},    64'(pc_out),    64'(ep));
    check({tag, ".in_ready"},  64'(in_ready),  64'(eir));
    check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(es));
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] ii,
                       input logic [31:0] pi, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    instr_in  = ii;
    pc_in     = pi;
    out_ready = ordy;
  endtask

  initial begin
    //           fl  iv  instr_in      pc_in   ordy  ev  instr_out     pc_out  ir  stall
    // streaming
    vecs[0]  = '{0, 1, 32'h2001_0000, 32'h00, 1,    1, 32'h2001_0000, 32'h00, 1, 0};
    vecs[1]  = '{0, 1, 32'h2001_0001, 32'h04, 1,    1, 32'h2001_0001, 32'h04, 1, 0};
    vecs[2]  = '{0, 1, 32'h2001_0002, 32'h08, 1,    1, 32'h2001_0002, 32'h08, 1, 0};
    vecs[3]  = '{0, 1, 32'h2001_0003, 32'h0C, 1,    1, 32'h2001_0003, 32'h0C, 1, 0};
    vecs[4]  = '{0, 0, 32'h0,         32'h00, 1,    0, NOP,           32'h0C, 1, 0};
    // back-pressure: A then B, C offered while full
    vecs[5]  = '{0, 1, 32'hAAAA_0010, 32'h10, 0,    1, 32'hAAAA_0010, 32'h10, 1, 0};
    vecs[6]  = '{0, 1, 32'hBBBB_0014, 32'h14, 0,    1, 32'hAAAA_0010, 32'h10, 0, 1};
    vecs[7]  = '{0, 1, 32'hCCCC_0018, 32'h18, 0,    1, 32'hAAAA_0010, 32'h10, 0, 2};
    vecs[8]  = '{0, 0, 32'h0,         32'h00, 0,    1, 32'hAAAA_0010, 32'h10, 0, 3};
    vecs[9]  = '{0, 0, 32'h0,         32'h00, 1,    1, 32'hBBBB_0014, 32'h14, 1, 3};
    vecs[10] = '{0, 0, 32'h0,         32'h00, 1,    0, NOP,           32'h14, 1, 3};
    // flush while TWO with C offered
    vecs[11] = '{0, 1, 32'h1111_0020, 32'h20, 0,    1, 32'h1111_0020, 32'h20, 1, 3};
    vecs[12] = '{0, 1, 32'h2222_0024, 32'h24, 0,    1, 32'h1111_0020, 32'h20, 0, 4};
    vecs[13] = '{1, 1, 32'h3333_0028, 32'h28, 0,    0, NOP,           32'h20, 1, 4};
    vecs[14] = '{0, 0, 32'h0,         32'h00, 1,    0, NOP,           32'h20, 1, 4};
    // flush while EMPTY drops the incoming word
    vecs[15] = '{1, 1, 32'h4444_0030, 32'h30, 1,    0, NOP,           32'h20, 1, 4};
    // accept & deliver in ONE, then flush while delivering
    vecs[16] = '{0, 1, 32'h5555_0040, 32'h40, 0,    1, 32'h5555_0040, 32'h40, 1, 4};
    vecs[17] = '{0, 1, 32'h6666_0044, 32'h44, 1,    1, 32'h6666_0044, 32'h44, 1, 4};
    vecs[18] = '{1, 0, 32'h0,         32'h00, 1,    0, NOP,           32'h44, 1, 4};

    reset = 1'b1;
    drive(0, 0, 32'h0, 32'h0, 0);
    #1;
    check_all("reset", 0, NOP, RST_PC, 0, 0);
    step();
    reset = 1'b0;
    #1;
    check_all("post_reset", 0, NOP, RST_PC, 1, 0);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].ii, vecs[i].pi, vecs[i].ordy);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].ep,
                vecs[i].eir, vecs[i].es);
    end

    // Asynchronous reset mid-cycle while holding one word.
    drive(0, 1, 32'h7777_0050, 32'h50, 0);
    step();
    check_all("pre_async", 1, 32'h7777_0050, 32'h50, 1, 4);
    drive(0, 1, 32'h8888_0054, 32'h54, 0);
    #2;
    reset = 1'b1;
    #1;
    check_all("async_reset", 0, NOP, RST_PC, 0, 0);
    step();
    check_all("held_reset", 0, NOP, RST_PC, 0, 0);
    drive(0, 0, 32'h0, 32'h0, 0);
    reset = 1'b0;
    #1;
    check("release.in_ready", 64'(in_ready), 64'd1);

    // Stall counter saturation at 2^4-1.
    drive(0, 1, 32'h9999_0060, 32'h60, 0);
    step();
    check_all("sat_load", 1, 32'h9999_0060, 32'h60, 1, 0);
    drive(0, 0, 32'h0, 32'h0, 0);
    for (int i = 1; i <= 20; i++) begin
      step();
      check($sformatf("sat%0d.stall_cnt", i), 64'(stall_cnt), 64'((i > 15) ? 15 : i));
    end
    check("sat.out_valid", 64'(out_valid), 64'd1);
    check("sat.instr_out", 64'(instr_out), 64'h9999_0060);

    // Drain to empty: pc_out retains the delivered PC; flush does not clear stall_cnt.
    drive(0, 0, 32'h0, 32'h0, 1);
    step();
    check_all("drain", 0, NOP, 32'h60, 1, 15);
    drive(1, 0, 32'h0, 32'h0, 0);
    step();
    check_all("flush_empty", 0, NOP, 32'h60, 1, 15);
    drive(0, 0, 32'h0, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
